// File: rtl/nn_pixel_loader.sv
// rtl/nn_pixel_loader.sv - unpacks 32-bit pixel words into the NN core pixel port and sequences start/done
module nn_pixel_loader #(
    parameter int N_IN    = 784,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_we,
    input  logic [31:0] word_data,
    output logic        word_ready,
    input  logic        clear,
    output logic        pix_we,
    output logic [9:0]  pix_addr,
    output logic [7:0]  pix_data,
    output logic        core_start,
    input  logic        core_done,
    input  logic [3:0]  core_pred,
    output logic        busy,
    output logic        result_valid,
    output logic [3:0]  result,
    output logic        overrun,
    output logic        timeout_err,
    output logic [9:0]  pix_count
);

    localparam int         CNT_W     = $clog2(TIMEOUT) + 1;
    localparam logic [9:0] LAST_ADDR = 10'(N_IN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNPACK = 2'd1,
        ST_START  = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      hold_q, hold_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [9:0]       ptr_q, ptr_d;
    logic [9:0]       pix_count_q, pix_count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_err_q, timeout_err_d;

    logic             last_byte;
    logic             accept;

    // Byte currently presented is the final pixel of the image
    assign last_byte = (ptr_q == LAST_ADDR);
    // A word is taken only when the loader is ready and no abort is pending
    assign accept    = word_we && word_ready && !clear;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides every transition
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    if (last_byte) begin
                        state_d = ST_START;
                    end else if (byte_idx_q == 2'd3) begin
                        state_d = accept ? ST_UNPACK : ST_IDLE;
                    end
                end
                ST_START: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done || (cnt_q == CNT_LAST)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode; strobes are suppressed in a clear cycle
    always_comb begin
        word_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_UNPACK) && (byte_idx_q == 2'd3) && !last_byte);
        pix_we     = (state_q == ST_UNPACK) && !clear;
        core_start = (state_q == ST_START) && !clear;
        busy       = (state_q != ST_IDLE);
        pix_addr   = ptr_q;
        pix_data   = hold_q[{byte_idx_q, 3'b000} +: 8];
    end

    // Datapath next values: hold register, pointers, timeout counter and sticky flags
    always_comb begin
        hold_d         = hold_q;
        byte_idx_d     = byte_idx_q;
        ptr_d          = ptr_q;
        pix_count_d    = pix_count_q;
        cnt_d          = '0;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        overrun_d      = overrun_q;
        timeout_err_d  = timeout_err_q;

        if (clear) begin
            ptr_d          = '0;
            pix_count_d    = '0;
            byte_idx_d     = '0;
            result_valid_d = 1'b0;
            overrun_d      = 1'b0;
            timeout_err_d  = 1'b0;
        end else begin
            if (word_we && !word_ready) begin
                overrun_d = 1'b1;
            end

            if ((state_q == ST_START) || (state_q == ST_WAIT)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        hold_d     = word_data;
                        byte_idx_d = 2'd0;
                        if (ptr_q == 10'd0) begin
                            // first word of a new image wipes the previous outcome
                            result_valid_d = 1'b0;
                            timeout_err_d  = 1'b0;
                            pix_count_d    = '0;
                        end
                    end
                end
                ST_UNPACK: begin
                    pix_count_d = pix_count_q + 10'd1;
                    if (last_byte) begin
                        ptr_d      = '0;
                        byte_idx_d = 2'd0;
                    end else begin
                        ptr_d = ptr_q + 10'd1;
                        if (accept) begin
                            hold_d     = word_data;
                            byte_idx_d = 2'd0;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (core_done) begin
                        result_d       = core_pred;
                        result_valid_d = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_err_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q         <= '0;
            byte_idx_q     <= '0;
            ptr_q          <= '0;
            pix_count_q    <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            hold_q         <= hold_d;
            byte_idx_q     <= byte_idx_d;
            ptr_q          <= ptr_d;
            pix_count_q    <= pix_count_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;
    assign pix_count    = pix_count_q;

endmodule

// File: doc/nn_pixel_loader.md
Name: nn_pixel_loader

Overview:
- Upstream feeder for the NN inference core.
- Accepts packed 32-bit pixel words (4 pixels per word) from the AXI register block and unpacks them into the core's byte-wide pixel write port.
- Auto-pulses the core's start after the last pixel is written, then waits for done, latches the predicted class, and exposes status plus a timeout error to software.

Parameters:
- N_IN, 784, pixels per image; the last word may be partial (bytes beyond N_IN discarded).
- TIMEOUT, 4096, max cycles from start pulse to done before the error flag is set.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset (asserted when 0)
- word_we  input  1  one-cycle write strobe for word_data
- word_data  input  32  pixels: [7:0] first, [15:8], [23:16], [31:24] last
- word_ready  output  1  loader can accept word_we this cycle
- clear  input  1  one-cycle abort: pointer to 0, flags cleared
- pix_we  output  1  pixel write strobe to core
- pix_addr  output  10  pixel address 0..N_IN-1
- pix_data  output  8  pixel value
- core_start  output  1  one-cycle start pulse to core
- core_done  input  1  one-cycle done pulse from core
- core_pred  input  4  core predicted class, valid with core_done
- busy  output  1  high in UNPACK, START, WAIT
- result_valid  output  1  sticky until next image begins or clear
- result  output  4  latched class
- overrun  output  1  sticky: word_we while word_ready low
- timeout_err  output  1  sticky: TIMEOUT expired in WAIT
- pix_count  output  10  pixels written for current image

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; all outputs 0 except word_ready=1; pointer=0.
- States: IDLE, UNPACK, START, WAIT.
- IDLE: word_ready=1. word_we captures word_data into the hold register, byte_idx=0, goes to UNPACK. If pointer==0, result_valid and timeout_err clear in the same cycle.
- UNPACK: one byte per cycle. pix_we=1, pix_addr=pointer, pix_data=hold[8*byte_idx+:8]; pointer and pix_count increment each byte.
  - Latency: word accepted at edge T gives bytes at cycles T+1..T+4.
  - word_ready=1 only in the byte_idx==3 cycle when that byte is not address N_IN-1. A word accepted there continues UNPACK with no gap, so back-to-back words produce a continuous pix_we stream.
  - Byte at address N_IN-1 is written, then go to START. Remaining bytes of that word are discarded (no pix_we), and pointer returns to 0.
  - byte_idx==3 and not last, with no new word: return to IDLE.
- START: core_start=1 for exactly one cycle, timeout counter=0, then go to WAIT.
- WAIT: counter increments each cycle.
  - core_done: result<=core_pred, result_valid<=1, go to IDLE.
  - Counter reaches TIMEOUT-1 with no done: timeout_err<=1, go to IDLE, result unchanged.
  - core_done in any state other than WAIT is ignored.
- word_we while word_ready=0: word dropped, overrun<=1 (sticky until clear or reset).
- clear, from any state: go to IDLE; pointer, pix_count, result_valid, overrun, timeout_err<=0; result unchanged. No pix_we or core_start in that cycle.
- clear and word_we in the same cycle: clear wins, word dropped, overrun not set.
- Reset mid-UNPACK or mid-WAIT: same as reset from any state. Partial image is abandoned; the core's pixel memory keeps stale data.
- pix_addr never exceeds N_IN-1. pix_we is never asserted outside UNPACK.

Test Plan:
- Reset then 196 back-to-back words 0x03020100, 0x07060504, ... -> pix_we high for 784 consecutive cycles; pix_addr 0..783; pix_data[n]=n mod 256; core_start pulses once, one cycle after addr 783.
- Core model returns done with pred=7 twenty cycles after start -> result=7, result_valid=1, busy=0. Next word_we clears result_valid.
- N_IN=6, two words 0xDDCCBBAA, 0x44332211 -> writes AA,BB,CC,DD,11,22 at addrs 0..5; bytes 33,44 are not written; start follows.
- word_we asserted on the cycle after acceptance of a word (byte_idx=0) -> word dropped, overrun=1, the pixel stream is unaffected; clear -> overrun=0.
- TIMEOUT=16, core never asserts done -> timeout_err=1 exactly 16 cycles after core_start, state IDLE, result_valid=0.
- rst=0 asserted after 100 pixels -> all outputs reset next edge. A fresh image then starts writing at pix_addr 0.
